// File: rtl/pixunpack_if.sv
// Pixel unpacker bus: FIFO word side plus pixel side toward the timing generator.
// The master modport is the unpacker itself; slave is its environment.
interface pixunpack_if #(
  parameter int DW = 32
);
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_word;
  logic          o_fifo_rd;
  logic          i_rd;
  logic [7:0]    o_pixel;
  logic          o_pix_valid;

  modport master (
    input  i_fifo_valid, i_fifo_word, i_rd,
    output o_fifo_rd, o_pixel, o_pix_valid
  );

  modport slave (
    output i_fifo_valid, i_fifo_word, i_rd,
    input  o_fifo_rd, o_pixel, o_pix_valid
  );
endinterface

// File: rtl/pixunpack.sv
// Pixel unpacker: splits DW-bit FIFO words into 1/2/4/8-bit palette indices,
// MSB-first, one pixel per i_rd. Depth is latched per frame; line starts drop
// any partial word. Underflows (i_rd with nothing to show) are counted.
module pixunpack #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          i_pixclk,
  input  logic          i_reset,
  input  logic          i_newframe,
  input  logic          i_newline,
  input  logic [1:0]    i_bpp,
  pixunpack_if.master   bus,
  output logic          o_underflow,
  output logic [CW-1:0] o_underflow_count
);
  localparam int FW = $clog2(DW + 1);

  logic [DW-1:0] sr;
  logic [FW-1:0] fill;
  logic [1:0]    bpp_q;
  logic [FW-1:0] ppw;
  logic [3:0]    shamt;
  logic          fill_zero, fill_one, ctl, load;

  assign fill_zero = (fill == '0);
  assign fill_one  = (fill == FW'(1));
  // Control strobes own the cycle: no pop, no pixel consumption.
  assign ctl       = i_reset | i_newframe | i_newline;
  assign shamt     = 4'(1) << bpp_q;

  // Pop when empty, or when the last pixel of the word is being taken now,
  // so back-to-back words stream without a bubble.
  assign bus.o_fifo_rd   = !ctl && (fill_zero || (fill_one && bus.i_rd));
  assign load            = bus.o_fifo_rd && bus.i_fifo_valid;
  assign bus.o_pix_valid = !fill_zero;

  // Pixels per word for the latched depth.
  always_comb begin
    ppw = FW'(DW);
    case (bpp_q)
      2'd0: ppw = FW'(DW);
      2'd1: ppw = FW'(DW / 2);
      2'd2: ppw = FW'(DW / 4);
      2'd3: ppw = FW'(DW / 8);
      default: ppw = FW'(DW);
    endcase
  end

  // Current pixel: top bits of the shift register, zero-extended; 0 when empty.
  always_comb begin
    bus.o_pixel = 8'h00;
    if (!fill_zero) begin
      case (bpp_q)
        2'd0: bus.o_pixel = {7'b0, sr[DW-1]};
        2'd1: bus.o_pixel = {6'b0, sr[DW-1 -: 2]};
        2'd2: bus.o_pixel = {4'b0, sr[DW-1 -: 4]};
        2'd3: bus.o_pixel = sr[DW-1 -: 8];
        default: bus.o_pixel = 8'h00;
      endcase
    end
  end

  // Shift register, fill count, depth latch and underflow tracking.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      sr                <= '0;
      fill              <= '0;
      bpp_q             <= i_bpp;
      o_underflow       <= 1'b0;
      o_underflow_count <= '0;
    end else begin
      o_underflow <= 1'b0;
      if (i_newframe) begin
        sr    <= '0;
        fill  <= '0;
        bpp_q <= i_bpp;
      end else if (i_newline) begin
        sr   <= '0;
        fill <= '0;
      end else begin
        // A read while empty is an underflow even if a word lands this cycle;
        // that word's first pixel is kept for the next read.
        if (bus.i_rd && fill_zero) begin
          o_underflow <= 1'b1;
          if (o_underflow_count != {CW{1'b1}})
            o_underflow_count <= o_underflow_count + 1'b1;
        end
        if (load) begin
          sr   <= bus.i_fifo_word;
          fill <= ppw;
        end else if (bus.i_rd && !fill_zero) begin
          sr   <= fill_one ? '0 : (sr << shamt);
          fill <= fill - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixunpack.sv
// Bench for pixunpack: directed vector table, corner-case sequences and a
// random stream, all checked against a queue-of-pixels reference model.
module tb_pixunpack;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, nf, nl;
  logic [1:0]    bpp;
  logic          uf;
  logic [CW-1:0] ucnt;

  always #5 clk = ~clk;

  pixunpack_if #(.DW(DW)) bus ();

  pixunpack #(.DW(DW), .CW(CW)) dut (
    .i_pixclk          (clk),
    .i_reset           (rst),
    .i_newframe        (nf),
    .i_newline         (nl),
    .i_bpp             (bpp),
    .bus               (bus),
    .o_underflow       (uf),
    .o_underflow_count (ucnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pixels still to be shown from the current word.
  logic [7:0]    q[$];
  logic [1:0]    m_b;
  logic          m_uf;
  logic [CW-1:0] m_cnt;
  bit            chk_en = 0;

  // Outputs observed in the most recent step.
  logic [7:0]    obs_pix;
  logic          obs_pv, obs_frd, obs_uf;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, compare with the model, advance.
  task automatic step(input logic r, input logic f, input logic n, input logic [1:0] b,
                      input logic fv, input logic [31:0] w, input logic rd);
    logic exp_frd;
    int   wb;
    rst = r; nf = f; nl = n; bpp = b;
    bus.i_fifo_valid = fv; bus.i_fifo_word = w; bus.i_rd = rd;
    @(negedge clk);
    obs_pix = bus.o_pixel; obs_pv = bus.o_pix_valid; obs_frd = bus.o_fifo_rd;
    obs_uf = uf; obs_cnt = ucnt;
    exp_frd = !(r | f | n) && (q.size() == 0 || (q.size() == 1 && rd));
    if (chk_en) begin
      chk("pixel", 32'(obs_pix), 32'(q.size() != 0 ? q[0] : 8'h00));
      chk("pix_valid", 32'(obs_pv), 32'(q.size() != 0));
      chk("fifo_rd", 32'(obs_frd), 32'(exp_frd));
      chk("underflow", 32'(obs_uf), 32'(m_uf));
      chk("uf_count", 32'(obs_cnt), 32'(m_cnt));
    end
    if (r) begin
      q.delete(); m_b = b; m_cnt = '0; m_uf = 1'b0; chk_en = 1;
    end else if (f || n) begin
      q.delete(); m_uf = 1'b0;
      if (f) m_b = b;
    end else begin
      m_uf = rd && (q.size() == 0);
      if (m_uf && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (exp_frd && fv) begin
        wb = 1 << m_b;
        for (int i = 0; i < DW / wb; i++)
          q.push_back(8'((w >> (DW - wb * (i + 1))) & ((1 << wb) - 1)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rd;
    logic          fv;
    logic [31:0]   w;
    logic          nl;
    logic [7:0]    pix;
    logic          pv;
    logic          frd;
    logic          uf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int ones, pops, ufs;

    // 8bpp stream, back-to-back words, drain to empty, underflow, newline with rd.
    tbl[0]  = '{1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'h11223344, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'h11223344, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'h11223344, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'h11223344, 1'b0, 8'hD4, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 1'b1, 32'h55667788, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1};
    tbl[12] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1};

    rst = 1'b1; nf = 1'b0; nl = 1'b0; bpp = 2'd3;
    bus.i_fifo_valid = 1'b0; bus.i_fifo_word = '0; bus.i_rd = 1'b0;
    @(posedge clk); #1;

    // Reset state, with rd and a valid word offered during reset.
    step(1, 0, 0, 2'd3, 1, 32'hFFFFFFFF, 1);
    step(0, 0, 0, 2'd3, 0, 32'h0, 0);
    chk("rst_pixel", 32'(obs_pix), 32'h0);
    chk("rst_pv", 32'(obs_pv), 32'h0);
    chk("rst_uf", 32'(obs_uf), 32'h0);
    chk("rst_cnt", 32'(obs_cnt), 32'h0);

    step(1, 0, 0, 2'd3, 0, 32'h0, 0);
    for (int i = 0; i < 14; i++) begin
      step(0, 0, tbl[i].nl, 2'd3, tbl[i].fv, tbl[i].w, tbl[i].rd);
      chk($sformatf("tbl%0d_pix", i), 32'(obs_pix), 32'(tbl[i].pix));
      chk($sformatf("tbl%0d_pv", i), 32'(obs_pv), 32'(tbl[i].pv));
      chk($sformatf("tbl%0d_frd", i), 32'(obs_frd), 32'(tbl[i].frd));
      chk($sformatf("tbl%0d_uf", i), 32'(obs_uf), 32'(tbl[i].uf));
      chk($sformatf("tbl%0d_cnt", i), 32'(obs_cnt), 32'(tbl[i].cnt));
    end

    // 1bpp: 0x80000001 gives 1, thirty zeros, 1; then the next word follows.
    step(0, 1, 0, 2'd0, 0, 32'h0, 0);
    step(0, 0, 0, 2'd0, 1, 32'h80000001, 1);
    ones = 0; pops = 0;
    for (int i = 1; i <= 32; i++) begin
      step(0, 0, 0, 2'd0, 1, 32'h80000001, 1);
      ones += int'(obs_pix);
      if (obs_frd) pops++;
      if (i == 1)  chk("bpp1_first", 32'(obs_pix), 32'h1);
      if (i == 32) chk("bpp1_last_pop", 32'(obs_frd), 32'h1);
    end
    chk("bpp1_ones", 32'(ones), 32'd2);
    chk("bpp1_pops", 32'(pops), 32'd1);
    step(0, 0, 0, 2'd0, 0, 32'h0, 0);
    chk("bpp1_next", 32'(obs_pix), 32'h1);

    // 4bpp: newline after three reads drops the rest of the word.
    step(0, 1, 0, 2'd2, 0, 32'h0, 0);
    step(0, 0, 0, 2'd2, 1, 32'h12345678, 0);
    step(0, 0, 0, 2'd2, 0, 32'h0, 1);
    chk("nl_p0", 32'(obs_pix), 32'h1);
    step(0, 0, 0, 2'd2, 0, 32'h0, 1);
    step(0, 0, 0, 2'd2, 0, 32'h0, 1);
    chk("nl_p2", 32'(obs_pix), 32'h3);
    step(0, 0, 1, 2'd2, 0, 32'h0, 1);
    step(0, 0, 0, 2'd2, 1, 32'h9ABCDEF0, 0);
    chk("nl_empty", 32'(obs_pv), 32'h0);
    chk("nl_pop", 32'(obs_frd), 32'h1);
    step(0, 0, 0, 2'd2, 0, 32'h0, 0);
    chk("nl_next", 32'(obs_pix), 32'h9);

    // Underflow x3 on an empty FIFO; count survives a new frame.
    step(1, 0, 0, 2'd3, 0, 32'h0, 0);
    ufs = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 2'd3, 0, 32'h0, 1);
      chk("uf_pix", 32'(obs_pix), 32'h0);
      ufs += int'(obs_uf);
    end
    step(0, 0, 0, 2'd3, 0, 32'h0, 0);
    ufs += int'(obs_uf);
    chk("uf_pulses", 32'(ufs), 32'd3);
    chk("uf_cnt3", 32'(obs_cnt), 32'd3);
    step(0, 1, 0, 2'd3, 0, 32'h0, 0);
    step(0, 0, 0, 2'd3, 0, 32'h0, 0);
    chk("uf_keep", 32'(obs_cnt), 32'd3);

    // Saturation: 17 events in total on a 4-bit counter.
    for (int i = 0; i < 14; i++) step(0, 0, 0, 2'd3, 0, 32'h0, 1);
    step(0, 0, 0, 2'd3, 0, 32'h0, 0);
    chk("uf_sat", 32'(obs_cnt), 32'hF);
    step(0, 0, 0, 2'd3, 0, 32'h0, 0);
    chk("uf_sat_hold", 32'(obs_cnt), 32'hF);

    // Depth change mid-frame is ignored until the next frame start.
    step(1, 0, 0, 2'd3, 0, 32'h0, 0);
    step(0, 0, 0, 2'd1, 1, 32'hC0FFEE11, 0);
    step(0, 0, 0, 2'd1, 0, 32'h0, 1);
    chk("bpp_mid0", 32'(obs_pix), 32'hC0);
    step(0, 0, 0, 2'd1, 0, 32'h0, 1);
    chk("bpp_mid1", 32'(obs_pix), 32'hFF);
    step(0, 0, 0, 2'd1, 0, 32'h0, 1);
    step(0, 0, 0, 2'd1, 0, 32'h0, 1);
    chk("bpp_mid3", 32'(obs_pix), 32'h11);
    step(0, 1, 0, 2'd1, 0, 32'h0, 0);
    step(0, 0, 0, 2'd1, 1, 32'hE4000000, 0);
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 2'd1, 0, 32'h0, 1);
      if (i < 4) chk($sformatf("bpp2_p%0d", i), 32'(obs_pix), 32'(3 - i));
      if (obs_frd) pops++;
      if (i == 15) chk("bpp2_last_pop", 32'(obs_frd), 32'h1);
    end
    chk("bpp2_pops", 32'(pops), 32'd1);

    // Random traffic against the model.
    step(1, 0, 0, 2'($urandom_range(0, 3)), 0, 32'h0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
